// File: rtl/bus_rr_interconnect.sv
// Multi-host, multi-device bus: round-robin arbitration, in-order in-flight tracking FIFO, decode-error pseudo-device.
// Optional per-host grant counters are enabled with `define BUS_PERF_CNT_EN.
`timescale 1ns/1ps
module bus_rr_interconnect #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned NrDevices      = 3,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned AddressWidth   = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      host_req_i     [NrHosts],
    input  logic                      host_we_i      [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
    output logic                      host_gnt_o     [NrHosts],
    output logic                      host_rvalid_o  [NrHosts],
    output logic                      host_err_o     [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],

    output logic                      device_req_o   [NrDevices],
    output logic                      device_we_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic                      device_rvalid_i[NrDevices],
    input  logic                      device_err_i   [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices],

    output logic                      protocol_err_o,
    output logic [31:0]               perf_grant_cnt_o [NrHosts]
);

    localparam int unsigned HostW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int unsigned TgtW  = $clog2(NrDevices + 1);
    localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    localparam logic [TgtW-1:0]  ErrTgt   = TgtW'(NrDevices);
    localparam logic [CntW-1:0]  MaxCnt   = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(MaxOutstanding - 1);
    localparam logic [HostW-1:0] LastHost = HostW'(NrHosts - 1);

    logic [HostW-1:0] rr_q, rr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [TgtW-1:0]  last_tgt_q, last_tgt_d;
    logic             err_rsp_q, err_rsp_d;
    logic             proto_err_q, proto_err_d;

    logic [HostW-1:0] fifo_host_q [MaxOutstanding];
    logic [TgtW-1:0]  fifo_tgt_q  [MaxOutstanding];

    logic             cand_found;
    logic [HostW-1:0] cand_idx;
    logic [TgtW-1:0]  cand_tgt;
    logic             grant;
    logic             push;
    logic             pop;

    logic [HostW-1:0] head_host;
    logic [TgtW-1:0]  head_tgt;
    logic             rsp_valid;
    logic             rsp_err;
    logic [DataWidth-1:0] rsp_rdata;
    logic             spurious;

    // Round-robin: first requester at/after the pointer, else the lowest requester (wrap).
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!cand_found && host_req_i[h] && (HostW'(h) >= rr_q)) begin
                cand_found = 1'b1;
                cand_idx   = HostW'(h);
            end
        end
        for (int unsigned h = 0; h < NrHosts; h++) begin
            if (!cand_found && host_req_i[h]) begin
                cand_found = 1'b1;
                cand_idx   = HostW'(h);
            end
        end
    end

    always_comb begin
        cand_tgt = ErrTgt;
        for (int unsigned d = NrDevices; d > 0; d--) begin
            if ((host_addr_i[cand_idx] & cfg_device_addr_mask_i[d-1]) == cfg_device_addr_base_i[d-1]) begin
                cand_tgt = TgtW'(d - 1);
            end
        end
    end

    // Only same-target issue while busy, so every in-flight entry shares one target.
    always_comb begin
        grant = !rst_i && cand_found && (cnt_q < MaxCnt) &&
                ((cnt_q == '0) || (cand_tgt == last_tgt_q));
        push  = grant;
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = grant && (cand_idx == HostW'(h));
        end
        for (int unsigned d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = grant && (cand_tgt == TgtW'(d));
            device_we_o[d]    = host_we_i[cand_idx];
            device_addr_o[d]  = host_addr_i[cand_idx];
            device_be_o[d]    = host_be_i[cand_idx];
            device_wdata_o[d] = host_wdata_i[cand_idx];
        end
    end

    always_comb begin
        head_host = fifo_host_q[rd_ptr_q];
        head_tgt  = fifo_tgt_q[rd_ptr_q];
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        if (head_tgt == ErrTgt) begin
            rsp_valid = err_rsp_q;
            rsp_err   = 1'b1;
        end else begin
            for (int unsigned d = 0; d < NrDevices; d++) begin
                if (head_tgt == TgtW'(d)) begin
                    rsp_valid = device_rvalid_i[d];
                    rsp_err   = device_err_i[d];
                    rsp_rdata = device_rdata_i[d];
                end
            end
        end
        pop = (cnt_q != '0) && rsp_valid;
    end

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = pop && (head_host == HostW'(h));
            host_err_o[h]    = pop && (head_host == HostW'(h)) && rsp_err;
            host_rdata_o[h]  = (pop && (head_host == HostW'(h))) ? rsp_rdata : '0;
        end
    end

    always_comb begin
        spurious = 1'b0;
        for (int unsigned d = 0; d < NrDevices; d++) begin
            if (device_rvalid_i[d] && ((cnt_q == '0) || (head_tgt != TgtW'(d)))) begin
                spurious = 1'b1;
            end
        end
    end

    always_comb begin
        rr_d        = rr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        last_tgt_d  = last_tgt_q;
        err_rsp_d   = push && (cand_tgt == ErrTgt);
        proto_err_d = proto_err_q | spurious;
        if (push) begin
            rr_d       = (cand_idx == LastHost) ? '0 : cand_idx + 1'b1;
            wr_ptr_d   = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            last_tgt_d = cand_tgt;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q        <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            last_tgt_q  <= '0;
            err_rsp_q   <= 1'b0;
            proto_err_q <= 1'b0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                fifo_host_q[i] <= '0;
                fifo_tgt_q[i]  <= '0;
            end
        end else begin
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_tgt_q  <= last_tgt_d;
            err_rsp_q   <= err_rsp_d;
            proto_err_q <= proto_err_d;
            if (push) begin
                fifo_host_q[wr_ptr_q] <= cand_idx;
                fifo_tgt_q[wr_ptr_q]  <= cand_tgt;
            end
        end
    end

    assign protocol_err_o = proto_err_q;

`ifdef BUS_PERF_CNT_EN
    logic [31:0] perf_cnt_q [NrHosts];
    logic [31:0] perf_cnt_d [NrHosts];

    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            perf_cnt_d[h] = perf_cnt_q[h];
            if (host_gnt_o[h] && (perf_cnt_q[h] != '1)) begin
                perf_cnt_d[h] = perf_cnt_q[h] + 32'd1;
            end
            perf_grant_cnt_o[h] = perf_cnt_q[h];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                perf_cnt_q[h] <= '0;
            end
        end else begin
            for (int unsigned h = 0; h < NrHosts; h++) begin
                perf_cnt_q[h] <= perf_cnt_d[h];
            end
        end
    end
`else
    always_comb begin
        for (int unsigned h = 0; h < NrHosts; h++) begin
            perf_grant_cnt_o[h] = '0;
        end
    end
`endif

endmodule

// File: tb/tb_bus_rr_interconnect.sv
// Directed bench for bus_rr_interconnect: RR contention, decode error, ordering stall, FIFO full, spurious/reset, grant counters.
`timescale 1ns/1ps
module tb_bus_rr_interconnect;

    localparam int unsigned NH = 2;
    localparam int unsigned ND = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned MO = 2;
    localparam int unsigned RAM = 0;
    localparam int unsigned TMR = 1;
    localparam int unsigned SIM = 2;
`ifdef BUS_PERF_CNT_EN
    localparam logic [31:0] PerfExp1 = 32'd5;
`else
    localparam logic [31:0] PerfExp1 = 32'd0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            host_req    [NH];
    logic            host_we     [NH];
    logic [AW-1:0]   host_addr   [NH];
    logic [DW/8-1:0] host_be     [NH];
    logic [DW-1:0]   host_wdata  [NH];
    logic            host_gnt    [NH];
    logic            host_rvalid [NH];
    logic            host_err    [NH];
    logic [DW-1:0]   host_rdata  [NH];
    logic            dev_req     [ND];
    logic            dev_we      [ND];
    logic [AW-1:0]   dev_addr    [ND];
    logic [DW/8-1:0] dev_be      [ND];
    logic [DW-1:0]   dev_wdata   [ND];
    logic            dev_rvalid  [ND];
    logic            dev_err     [ND];
    logic [DW-1:0]   dev_rdata   [ND];
    logic [AW-1:0]   cfg_base    [ND];
    logic [AW-1:0]   cfg_mask    [ND];
    logic            protocol_err;
    logic [31:0]     perf_cnt    [NH];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    bus_rr_interconnect #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(host_gnt), .host_rvalid_o(host_rvalid), .host_err_o(host_err),
        .host_rdata_o(host_rdata),
        .device_req_o(dev_req), .device_we_o(dev_we), .device_addr_o(dev_addr),
        .device_be_o(dev_be), .device_wdata_o(dev_wdata),
        .device_rvalid_i(dev_rvalid), .device_err_i(dev_err), .device_rdata_i(dev_rdata),
        .cfg_device_addr_base_i(cfg_base), .cfg_device_addr_mask_i(cfg_mask),
        .protocol_err_o(protocol_err), .perf_grant_cnt_o(perf_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_we[h]    = 1'b0;
            host_addr[h]  = '0;
            host_be[h]    = '0;
            host_wdata[h] = '0;
        end
        for (int d = 0; d < ND; d++) begin
            dev_rvalid[d] = 1'b0;
            dev_err[d]    = 1'b0;
            dev_rdata[d]  = '0;
        end
    endtask

    task automatic host_rd(input int h, input logic [31:0] addr);
        host_req[h]  = 1'b1;
        host_we[h]   = 1'b0;
        host_addr[h] = addr;
        host_be[h]   = 4'hF;
    endtask

    task automatic host_wr(input int h, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
        host_req[h]   = 1'b1;
        host_we[h]    = 1'b1;
        host_addr[h]  = addr;
        host_be[h]    = be;
        host_wdata[h] = data;
    endtask

    task automatic dev_rsp(input int d, input logic [31:0] data);
        dev_rvalid[d] = 1'b1;
        dev_rdata[d]  = data;
    endtask

    function automatic logic [31:0] dreq_vec();
        return {29'b0, dev_req[2], dev_req[1], dev_req[0]};
    endfunction

    initial begin
        cfg_base[RAM] = 32'h0010_0000; cfg_mask[RAM] = 32'hFFF0_0000;
        cfg_base[TMR] = 32'h0003_0000; cfg_mask[TMR] = 32'hFFFF_0000;
        cfg_base[SIM] = 32'h0002_0000; cfg_mask[SIM] = 32'hFFFF_0000;
        idle();
        rst = 1'b1;
        host_rd(0, 32'h0010_0000);
        tick(); tick();
        check_eq("rst_gnt0", 32'(host_gnt[0]), 32'd0);
        check_eq("rst_devreq", dreq_vec(), 32'd0);
        check_eq("rst_perr", 32'(protocol_err), 32'd0);
        check_eq("rst_rvalid0", 32'(host_rvalid[0]), 32'd0);
        check_eq("rst_rdata0", host_rdata[0], 32'd0);
        check_eq("rst_perf1", perf_cnt[1], 32'd0);
        idle();
        tick();
        rst = 1'b0;

        // Round-robin contention on RAM, 1-cycle device latency
        for (int k = 0; k < 4; k++) begin
            tick();
            idle();
            host_rd(0, 32'h0010_0010);
            host_rd(1, 32'h0010_0020);
            if (k > 0) dev_rsp(RAM, 32'hA000_0000 + 32'(k));
            settle();
            check_eq("rr_gnt0", 32'(host_gnt[0]), 32'(k % 2 == 0));
            check_eq("rr_gnt1", 32'(host_gnt[1]), 32'(k % 2 == 1));
            check_eq("rr_devaddr", dev_addr[RAM], (k % 2 == 0) ? 32'h0010_0010 : 32'h0010_0020);
            if (k > 0) begin
                check_eq("rr_rvalid", 32'(host_rvalid[(k-1) % 2]), 32'd1);
                check_eq("rr_rdata", host_rdata[(k-1) % 2], 32'hA000_0000 + 32'(k));
                check_eq("rr_rvalid_other", 32'(host_rvalid[k % 2]), 32'd0);
            end
        end
        tick(); idle(); dev_rsp(RAM, 32'hA000_0004); settle();
        check_eq("rr_last_rvalid1", 32'(host_rvalid[1]), 32'd1);
        check_eq("rr_last_rdata1", host_rdata[1], 32'hA000_0004);
        tick(); idle(); settle();
        check_eq("rr_quiet_rvalid1", 32'(host_rvalid[1]), 32'd0);
        check_eq("rr_no_perr", 32'(protocol_err), 32'd0);

        // Decode error
        tick(); idle(); host_rd(0, 32'h0005_0000); settle();
        check_eq("dec_gnt0", 32'(host_gnt[0]), 32'd1);
        check_eq("dec_no_devreq", dreq_vec(), 32'd0);
        tick(); idle(); settle();
        check_eq("dec_rvalid0", 32'(host_rvalid[0]), 32'd1);
        check_eq("dec_err0", 32'(host_err[0]), 32'd1);
        check_eq("dec_rdata0", host_rdata[0], 32'd0);
        check_eq("dec_rvalid1", 32'(host_rvalid[1]), 32'd0);
        tick(); idle(); settle();
        check_eq("dec_done_rvalid0", 32'(host_rvalid[0]), 32'd0);

        // Ordering stall: timer access waits for the RAM response to drain
        tick(); idle(); host_rd(0, 32'h0010_0100); settle();
        check_eq("ord_gnt0", 32'(host_gnt[0]), 32'd1);
        for (int c = 0; c < 2; c++) begin
            tick(); idle(); host_wr(1, 32'h0003_0004, 4'h3, 32'hDEAD_BEEF); settle();
            check_eq("ord_stall_gnt1", 32'(host_gnt[1]), 32'd0);
            check_eq("ord_stall_devreq", dreq_vec(), 32'd0);
        end
        tick(); idle(); host_wr(1, 32'h0003_0004, 4'h3, 32'hDEAD_BEEF); dev_rsp(RAM, 32'h1234_5678); settle();
        check_eq("ord_pop_rvalid0", 32'(host_rvalid[0]), 32'd1);
        check_eq("ord_pop_rdata0", host_rdata[0], 32'h1234_5678);
        check_eq("ord_pop_gnt1", 32'(host_gnt[1]), 32'd0);
        tick(); idle(); host_wr(1, 32'h0003_0004, 4'h3, 32'hDEAD_BEEF); settle();
        check_eq("ord_gnt1", 32'(host_gnt[1]), 32'd1);
        check_eq("ord_devreq", dreq_vec(), 32'd2);
        check_eq("ord_devaddr", dev_addr[TMR], 32'h0003_0004);
        check_eq("ord_devwe", 32'(dev_we[TMR]), 32'd1);
        check_eq("ord_devbe", 32'(dev_be[TMR]), 32'h3);
        check_eq("ord_devwdata", dev_wdata[TMR], 32'hDEAD_BEEF);
        tick(); idle(); dev_rsp(TMR, 32'hCAFE_0001); settle();
        check_eq("ord_rvalid1", 32'(host_rvalid[1]), 32'd1);
        check_eq("ord_rdata1", host_rdata[1], 32'hCAFE_0001);

        // FIFO full with 3-cycle RAM latency
        tick(); idle(); host_rd(0, 32'h0010_0200); settle();
        check_eq("full_gnt_a", 32'(host_gnt[0]), 32'd1);
        tick(); idle(); host_rd(0, 32'h0010_0204); settle();
        check_eq("full_gnt_b", 32'(host_gnt[0]), 32'd1);
        tick(); idle(); host_rd(0, 32'h0010_0208); settle();
        check_eq("full_block", 32'(host_gnt[0]), 32'd0);
        tick(); idle(); host_rd(0, 32'h0010_0208); dev_rsp(RAM, 32'h0000_0011); settle();
        check_eq("full_pop_rvalid", 32'(host_rvalid[0]), 32'd1);
        check_eq("full_pop_rdata", host_rdata[0], 32'h0000_0011);
        check_eq("full_pop_block", 32'(host_gnt[0]), 32'd0);
        tick(); idle(); host_rd(0, 32'h0010_0208); dev_rsp(RAM, 32'h0000_0022); settle();
        check_eq("full_gnt_c", 32'(host_gnt[0]), 32'd1);
        check_eq("full_rdata_b", host_rdata[0], 32'h0000_0022);
        tick(); idle(); settle();
        check_eq("full_gap_rvalid", 32'(host_rvalid[0]), 32'd0);
        tick(); idle();
        tick(); idle(); dev_rsp(RAM, 32'h0000_0033); settle();
        check_eq("full_rvalid_c", 32'(host_rvalid[0]), 32'd1);
        check_eq("full_rdata_c", host_rdata[0], 32'h0000_0033);

        // Spurious response with FIFO empty
        tick(); idle(); dev_rsp(SIM, 32'h5555_5555); settle();
        check_eq("spur_perr_pre", 32'(protocol_err), 32'd0);
        check_eq("spur_rvalid0", 32'(host_rvalid[0]), 32'd0);
        check_eq("spur_rvalid1", 32'(host_rvalid[1]), 32'd0);
        tick(); idle(); settle();
        check_eq("spur_perr", 32'(protocol_err), 32'd1);
        tick(); tick();
        check_eq("spur_perr_sticky", 32'(protocol_err), 32'd1);

        // Reset mid-transaction
        tick(); idle(); host_rd(0, 32'h0010_0300); settle();
        check_eq("mrst_gnt0_pre", 32'(host_gnt[0]), 32'd1);
        tick(); idle(); host_rd(0, 32'h0010_0300); host_rd(1, 32'h0010_0304);
        dev_rsp(RAM, 32'h0000_0077); rst = 1'b1; settle();
        check_eq("mrst_gnt0", 32'(host_gnt[0]), 32'd0);
        check_eq("mrst_gnt1", 32'(host_gnt[1]), 32'd0);
        check_eq("mrst_devreq", dreq_vec(), 32'd0);
        check_eq("mrst_perr", 32'(protocol_err), 32'd0);
        check_eq("mrst_rvalid0", 32'(host_rvalid[0]), 32'd0);
        tick(); rst = 1'b0; idle(); dev_rsp(RAM, 32'h0000_0077); settle();
        check_eq("mrst_late_rvalid0", 32'(host_rvalid[0]), 32'd0);
        tick(); idle(); host_rd(0, 32'h0010_0300); host_rd(1, 32'h0010_0304); settle();
        check_eq("mrst_late_perr", 32'(protocol_err), 32'd1);
        check_eq("mrst_ptr_gnt0", 32'(host_gnt[0]), 32'd1);
        check_eq("mrst_ptr_gnt1", 32'(host_gnt[1]), 32'd0);
        tick(); idle(); dev_rsp(RAM, 32'h0000_0044); settle();
        check_eq("mrst_rvalid0", 32'(host_rvalid[0]), 32'd1);
        check_eq("mrst_rdata0", host_rdata[0], 32'h0000_0044);

        // Five back-to-back decode-error grants to host 1
        tick(); idle(); rst = 1'b1;
        tick(); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); idle(); host_rd(1, 32'h0005_0000); settle();
            check_eq("perf_gnt1", 32'(host_gnt[1]), 32'd1);
            if (k > 0) begin
                check_eq("perf_err_rvalid1", 32'(host_rvalid[1]), 32'd1);
                check_eq("perf_err1", 32'(host_err[1]), 32'd1);
            end
        end
        tick(); idle(); settle();
        check_eq("perf_last_err1", 32'(host_err[1]), 32'd1);
        check_eq("perf_cnt1", perf_cnt[1], PerfExp1);
        check_eq("perf_cnt0", perf_cnt[0], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr_interconnect.md
Name: bus_rr_interconnect

Overview:
- Parameterised multi-host, multi-device bus for the simple-system family. Generalises the single-host bus to NrHosts requestors with round-robin arbitration.
- Supports up to MaxOutstanding pipelined transactions, kept in order by an in-flight tracking FIFO.
- Unmapped addresses get an internal decode-error response instead of hanging.
- Sits between core data ports and DMA-style hosts on one side, and RAM, timer and sim-ctrl devices on the other.

Parameters:
- NrHosts, 2, number of requestors (>=1)
- NrDevices, 3, number of mapped devices (>=1)
- DataWidth, 32, data bus width
- AddressWidth, 32, address bus width
- MaxOutstanding, 2, in-flight FIFO depth (>=1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- host_req_i / host_we_i  in  [NrHosts] x 1  request / write enable
- host_addr_i  in  [NrHosts] x AddressWidth  address
- host_be_i  in  [NrHosts] x DataWidth/8  byte enables
- host_wdata_i  in  [NrHosts] x DataWidth  write data
- host_gnt_o / host_rvalid_o / host_err_o  out  [NrHosts] x 1  grant / response valid / response error
- host_rdata_o  out  [NrHosts] x DataWidth  read data
- device_req_o / device_we_o  out  [NrDevices] x 1  request / write enable
- device_addr_o  out  [NrDevices] x AddressWidth  address
- device_be_o  out  [NrDevices] x DataWidth/8  byte enables
- device_wdata_o  out  [NrDevices] x DataWidth  write data
- device_rvalid_i / device_err_i  in  [NrDevices] x 1  response valid / error
- device_rdata_i  in  [NrDevices] x DataWidth  read data
- cfg_device_addr_base_i / cfg_device_addr_mask_i  in  [NrDevices] x AddressWidth  address map
- protocol_err_o  out  1  sticky flag for a spurious device response
- perf_grant_cnt_o  out  [NrHosts] x 32  grant counters (optional feature)

Behaviour:
- Reset (async, rst_i=1):
  - FIFO emptied.
  - RR pointer = 0.
  - Decode-error response register cleared.
  - protocol_err_o = 0; counters = 0.
  - All gnt/rvalid/err/req outputs = 0; rdata = 0.
- Decode:
  - Host address hits device d when (addr & mask[d]) == base[d].
  - If several devices hit, the lowest d wins.
  - No hit means target = ERR, a pseudo-device with index NrDevices.
- Arbitration:
  - Combinational, same cycle.
  - Candidate = first requesting host at or after the RR pointer, wrapping modulo NrHosts.
- Grant condition: candidate exists AND FIFO count < MaxOutstanding AND (FIFO empty OR target == device of most recently issued entry).
  - The last term prevents response reordering across devices.
  - Full blocks the grant even if a pop occurs in the same cycle; there is no rvalid->gnt combinational path.
- On grant to host h, target t:
  - host_gnt_o[h] = 1.
  - If t < NrDevices: device_req_o[t] = 1 with h's we/be/addr/wdata.
  - Push {h, t}.
  - RR pointer <= (h+1) mod NrHosts.
- Non-granted hosts: gnt = 0. Hosts hold req/addr/we/be/wdata stable until granted.
- Device outputs (addr/we/be/wdata) for non-requested devices: driven from the winning host; don't-care.
- ERR target: the cycle after the grant, the internal response is valid with err = 1 and rdata = 0. The pseudo-device has fixed latency 1.
- Response routing:
  - When the head entry {h, t} has its response valid (device_rvalid_i[t] or the internal ERR response):
    - host_rvalid_o[h] = 1, combinationally the same cycle.
    - host_rdata_o[h] = rdata of t.
    - host_err_o[h] = err of t.
    - Pop the head entry.
  - Push and pop in the same cycle: allowed; count unchanged.
- Spurious response: device_rvalid_i[d] with FIFO empty or d != head device.
  - Response dropped.
  - protocol_err_o <= 1, sticky until reset.
  - A device response arriving after a mid-operation reset is spurious by this rule.
- Reset mid-operation: in-flight entries are discarded. Hosts are expected to be reset together.
- Count width: $clog2(MaxOutstanding+1).
- FIFO pointers wrap modulo MaxOutstanding; non-power-of-2 depth is supported.

Optional Feature:
- Macro: BUS_PERF_CNT_EN.
- Defined: perf_grant_cnt_o[h] increments on every host_gnt_o[h] and saturates at 0xFFFFFFFF.
- Undefined: no counter flops; perf_grant_cnt_o tied to 0. Port list is unchanged.

Test Plan:
- Round-robin contention: hosts 0 and 1 both request RAM (base 0x100000, mask ~0xFFFFF) continuously; device responds 1 cycle later -> grants alternate 0,1,0,1. Each host gets its own rdata; no protocol_err_o.
- Decode error: host 0 reads 0x00050000 (unmapped) -> no device_req_o. The next cycle host_rvalid_o[0]=1, host_err_o[0]=1, rdata=0.
- Ordering stall: host 0 reads RAM, granted. The next cycle host 1 reads timer (0x30000) -> host 1 gnt held 0 until the RAM response pops, then granted.
- FIFO full: MaxOutstanding=2, RAM responds with 3-cycle latency; host 0 issues back-to-back reads -> 2 grants, third gnt=0 until the first rvalid, granted the cycle after the pop.
- Spurious and reset: device_rvalid_i[SimCtrl]=1 with FIFO empty -> protocol_err_o=1 and stays set. Assert rst_i mid-transaction -> all outputs 0 immediately, FIFO empty, pointer 0.
- BUS_PERF_CNT_EN defined: 5 grants to host 1 -> perf_grant_cnt_o[1]=5 and [0]=0. Force counter to 0xFFFFFFFF, one more grant -> stays 0xFFFFFFFF.
